// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: shares one pipelined FP adder core between two requesters.
// Build option FP_ARB_FIXED_PRIO_EN: requester 0 always wins (default round-robin).
`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

module fp_add_scheduler #(
  parameter int EXP_SIZE    = `EXP_SIZE,
  parameter int MANTIS_SIZE = `MANTIS_SIZE,
  parameter int LATENCY     = 3,
  localparam int W          = 1 + EXP_SIZE + MANTIS_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         core_valid,
  output logic [W-1:0] core_a,
  output logic [W-1:0] core_b,
  input  logic [W-1:0] core_result,
  output logic         rsp0_valid,
  output logic [W-1:0] rsp0_result,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp1_result,
  output logic         busy
);

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("fp_add_scheduler: LATENCY must be 1..8");
  end

  logic         w_grant0;
  logic         w_grant1;
  logic         w_accept;
  logic         w_rsp0;
  logic         w_rsp1;

  logic         r_core_valid;
  logic [W-1:0] r_core_a;
  logic [W-1:0] r_core_b;
  logic [LATENCY:0] r_tag_v;
  logic [LATENCY:0] r_tag_id;
  logic         r_rsp0_valid;
  logic         r_rsp1_valid;
  logic [W-1:0] r_rsp0_result;
  logic [W-1:0] r_rsp1_result;
  logic         r_busy;

`ifdef FP_ARB_FIXED_PRIO_EN
  assign w_grant0 = req0_valid;
  assign w_grant1 = req1_valid & ~req0_valid;
`else
  // r_last names the requester granted most recently; the other wins a tie
  logic r_last;

  assign w_grant0 = req0_valid & (~req1_valid | r_last);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_grant1;
    end
  end
`endif

  assign w_accept   = w_grant0 | w_grant1;
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_core_valid <= 1'b0;
      r_core_a     <= '0;
      r_core_b     <= '0;
    end else begin
      r_core_valid <= w_accept;
      if (w_accept) begin
        r_core_a <= w_grant1 ? req1_a : req0_a;
        r_core_b <= w_grant1 ? req1_b : req0_b;
      end
    end
  end

  // last tag stage lines up with the cycle core_result is valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v  <= {r_tag_v[LATENCY-1:0], w_accept};
      r_tag_id <= {r_tag_id[LATENCY-1:0], w_grant1};
    end
  end

  assign w_rsp0 = r_tag_v[LATENCY] & ~r_tag_id[LATENCY];
  assign w_rsp1 = r_tag_v[LATENCY] & r_tag_id[LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp0_valid  <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp1_result <= '0;
    end else begin
      r_rsp0_valid <= w_rsp0;
      r_rsp1_valid <= w_rsp1;
      if (w_rsp0) begin
        r_rsp0_result <= core_result;
      end
      if (w_rsp1) begin
        r_rsp1_result <= core_result;
      end
    end
  end

  // next-state view of issue reg and tags: covers issue through response pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= w_accept | (|r_tag_v);
    end
  end

  assign core_valid  = r_core_valid;
  assign core_a      = r_core_a;
  assign core_b      = r_core_b;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp0_result = r_rsp0_result;
  assign rsp1_result = r_rsp1_result;
  assign busy        = r_busy;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb_fp_add_scheduler: randomized bench with a behavioural adder core and
// an in-order scoreboard for fp_add_scheduler.
module tb_fp_add_scheduler;
  localparam int L = 3;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         core_valid;
  logic [W-1:0] core_a, core_b, core_result;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic         busy;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  fp_add_scheduler #(.LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .core_valid(core_valid), .core_a(core_a), .core_b(core_b),
    .core_result(core_result),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
    .busy(busy)
  );

  function automatic real s2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a,
                                       input logic [31:0] b);
    return r2s(s2r(a) + s2r(b));
  endfunction

  function automatic logic [31:0] rnd_op();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)),
            23'($urandom)};
  endfunction

  // adder core model: samples on the edge after issue, result L cycles later
  logic [W-1:0] pipe [0:L-1];
  always @(posedge clk) begin
    pipe[0] <= core_valid ? fadd(core_a, core_b) : 32'hDEADBEEF;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign core_result = pipe[L-1];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    int          c;
  } acc_t;
  typedef struct {
    bit          id;
    logic [31:0] r;
    int          c;
  } rsp_t;

  acc_t accq[$];
  rsp_t rspq[$];

  // recorder only: handshakes and response pulses with their cycle
  always @(negedge clk) begin
    if (req0_valid && req0_ready) accq.push_back('{1'b0, req0_a, req0_b, cyc});
    if (req1_valid && req1_ready) accq.push_back('{1'b1, req1_a, req1_b, cyc});
    if (rsp0_valid) rspq.push_back('{1'b0, rsp0_result, cyc});
    if (rsp1_valid) rspq.push_back('{1'b1, rsp1_result, cyc});
  end

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0; req0_b = '0;
    req1_a = '0; req1_b = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    accq.delete();
    rspq.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    @(posedge clk); #1;
    tests++;
    if ({core_valid, core_a, core_b, rsp0_valid, rsp0_result, rsp1_valid,
         rsp1_result, busy, req0_ready, req1_ready} !== '0) begin
      failed++;
      $display("FAIL reset_state: cv=%b busy=%b rsp=%b%b got nonzero, need 0",
               core_valid, busy, rsp0_valid, rsp1_valid);
    end
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = rnd_op(); req0_b = rnd_op();
    @(posedge clk); #1;
    req0_a = rnd_op(); req0_b = rnd_op();
    @(posedge clk); #1;
    req0_valid = 1'b0;
    tests++;
    if ({core_valid, busy} !== 2'b11) begin
      failed++;
      $display("FAIL reset_inflight: cv,busy=%b%b need 11", core_valid, busy);
    end
    @(posedge clk); #3 rst = 1'b1;
    #1;
    tests++;
    if ({core_valid, core_a, core_b, rsp0_valid, rsp0_result, rsp1_valid,
         rsp1_result, busy} !== '0) begin
      failed++;
      $display("FAIL reset_async: cv=%b busy=%b a=%h not cleared, need 0",
               core_valid, busy, core_a);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rspq.delete();
    accq.delete();
    repeat (8) @(posedge clk); #1;
    tests++;
    if (rspq.size() != 0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_discard: %0d rsp pulses busy=%b, need 0 and 0",
               rspq.size(), busy);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failed++;
      $display("FAIL single_ready: %b%b need 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    tests++;
    if (core_valid !== 1'b1 || core_a !== 32'h3F800000 || core_b !== 32'h40000000) begin
      failed++;
      $display("FAIL single_issue: cv=%b a=%h b=%h need 1 3f800000 40000000",
               core_valid, core_a, core_b);
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      tests++;
      if ({rsp0_valid, rsp1_valid} !== {(k == L + 1), 1'b0}) begin
        failed++;
        $display("FAIL single_pulse k=%0d: rsp0/1=%b%b need %b0",
                 k, rsp0_valid, rsp1_valid, (k == L + 1));
      end
      if (k == L + 1) begin
        tests++;
        if (rsp0_result !== 32'h40400000) begin
          failed++;
          $display("FAIL single_result: got %h need 40400000", rsp0_result);
        end
      end
    end
  endtask

  task automatic test_contention();
    bit g1;
    apply_reset();
    req0_valid = 1'b1; req0_a = rnd_op(); req0_b = rnd_op();
    req1_valid = 1'b1; req1_a = rnd_op(); req1_b = rnd_op();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      g1 = req1_ready;
      @(posedge clk); #1;
      if (g1) begin
        req1_a = rnd_op(); req1_b = rnd_op();
      end else begin
        req0_a = rnd_op(); req0_b = rnd_op();
      end
    end
    idle_inputs();
    repeat (L + 4) @(posedge clk); #1;
    tests++;
    if (accq.size() != 6 || rspq.size() != 6) begin
      failed++;
      $display("FAIL cont_count: acc=%0d rsp=%0d need 6 6",
               accq.size(), rspq.size());
    end
    for (int i = 0; i < accq.size() && i < 6; i++) begin
`ifdef FP_ARB_FIXED_PRIO_EN
      g1 = 1'b0;
`else
      g1 = 1'(i % 2);
`endif
      tests++;
      if (accq[i].id !== g1) begin
        failed++;
        $display("FAIL cont_grant%0d: got %0d need %0d", i, accq[i].id, g1);
      end
    end
    for (int i = 0; i < accq.size() && i < rspq.size(); i++) begin
      tests++;
      if ({rspq[i].id, rspq[i].r, rspq[i].c} !==
          {accq[i].id, fadd(accq[i].a, accq[i].b), accq[i].c + L + 2}) begin
        failed++;
        $display("FAIL cont_rsp%0d: id=%0d r=%h c=%0d need id=%0d r=%h c=%0d",
                 i, rspq[i].id, rspq[i].r, rspq[i].c, accq[i].id,
                 fadd(accq[i].a, accq[i].b), accq[i].c + L + 2);
      end
    end
  endtask

  task automatic test_stream();
    int ok;
    accq.delete();
    rspq.delete();
    req1_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      req1_a = rnd_op(); req1_b = rnd_op();
      @(posedge clk); #1;
      if (core_valid === 1'b1) ok++;
    end
    req1_valid = 1'b0;
    tests++;
    if (ok != 10) begin
      failed++;
      $display("FAIL stream_issue: core_valid high %0d cycles need 10", ok);
    end
    @(posedge clk); #1;
    tests++;
    if (core_valid !== 1'b0) begin
      failed++;
      $display("FAIL stream_idle: core_valid=%b need 0", core_valid);
    end
    repeat (L + 3) @(posedge clk); #1;
    tests++;
    if (accq.size() != 10 || rspq.size() != 10) begin
      failed++;
      $display("FAIL stream_count: acc=%0d rsp=%0d need 10 10",
               accq.size(), rspq.size());
    end
    for (int i = 0; i < accq.size() && i < rspq.size(); i++) begin
      tests++;
      if ({rspq[i].id, rspq[i].r, rspq[i].c} !==
          {1'b1, fadd(accq[i].a, accq[i].b), rspq[0].c + i}) begin
        failed++;
        $display("FAIL stream_rsp%0d: id=%0d r=%h c=%0d need id=1 r=%h c=%0d",
                 i, rspq[i].id, rspq[i].r, rspq[i].c,
                 fadd(accq[i].a, accq[i].b), rspq[0].c + i);
      end
    end
    if (rspq.size() > 0) begin
      tests++;
      if (rspq[0].c !== accq[0].c + L + 2) begin
        failed++;
        $display("FAIL stream_lat: first rsp cycle %0d need %0d",
                 rspq[0].c, accq[0].c + L + 2);
      end
    end
  endtask

  task automatic test_busy();
    bit b [0:L+3];
    apply_reset();
    req1_valid = 1'b1; req1_a = rnd_op(); req1_b = rnd_op();
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL busy_pre: got %b need 0", busy);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    for (int k = 0; k <= L + 3; k++) begin
      b[k] = busy;
      @(posedge clk); #1;
    end
    for (int k = 0; k <= L + 3; k++) begin
      tests++;
      if (b[k] !== (k <= L + 1)) begin
        failed++;
        $display("FAIL busy_k%0d: got %b need %b", k, b[k], (k <= L + 1));
      end
    end
  endtask

  task automatic test_random();
    bit last, v0, v1, e0, e1;
    apply_reset();
    last = 1'b1;
    for (int k = 0; k < 200; k++) begin
      v0 = $urandom_range(0, 3) != 0;
      v1 = $urandom_range(0, 3) != 0;
      req0_valid = v0; req0_a = rnd_op(); req0_b = rnd_op();
      req1_valid = v1; req1_a = rnd_op(); req1_b = rnd_op();
      @(negedge clk);
`ifdef FP_ARB_FIXED_PRIO_EN
      e0 = v0;
      e1 = v1 && !v0;
`else
      e0 = v0 && (!v1 || last);
      e1 = v1 && (!v0 || !last);
`endif
      tests++;
      if ({req0_ready, req1_ready} !== {e0, e1}) begin
        failed++;
        $display("FAIL rand_ready k=%0d: %b%b need %b%b",
                 k, req0_ready, req1_ready, e0, e1);
      end
      if (e0 || e1) last = e1;
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (L + 4) @(posedge clk); #1;
    tests++;
    if (rspq.size() != accq.size()) begin
      failed++;
      $display("FAIL rand_count: rsp=%0d need %0d", rspq.size(), accq.size());
    end
    for (int i = 0; i < accq.size() && i < rspq.size(); i++) begin
      tests++;
      if ({rspq[i].id, rspq[i].r, rspq[i].c} !==
          {accq[i].id, fadd(accq[i].a, accq[i].b), accq[i].c + L + 2}) begin
        failed++;
        $display("FAIL rand_rsp%0d: id=%0d r=%h c=%0d need id=%0d r=%h c=%0d",
                 i, rspq[i].id, rspq[i].r, rspq[i].c, accq[i].id,
                 fadd(accq[i].a, accq[i].b), accq[i].c + L + 2);
      end
    end
  endtask

`ifdef FP_ARB_FIXED_PRIO_EN
  task automatic test_fixed();
    apply_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_a = rnd_op(); req0_b = rnd_op();
      req1_a = rnd_op(); req1_b = rnd_op();
      @(negedge clk);
      tests++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
        failed++;
        $display("FAIL fixed_k%0d: %b%b need 10", k, req0_ready, req1_ready);
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failed++;
      $display("FAIL fixed_r1: %b%b need 01", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stream();
    test_busy();
    test_random();
`ifdef FP_ARB_FIXED_PRIO_EN
    test_fixed();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
